trivium_data_feeder: RTL and testbench

- Upstream stage of the Trivium cipher core. Buffers plaintext words from the host in a FIFO and serializes them MSB-first, one bit per cipher request.
- Exports the FIFO fill status as the 2-bit buffer-condition code consumed by the cipher core's control FSM.
- Drives the cipher's data bit, data strobe and end-of-word flag.

---
 rtl/trivium_data_feeder.sv | 174 +++++++++++++++++
 tb/tb_trivium_data_feeder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/trivium_data_feeder.sv
// -----------------------------------------------------------------------------
// trivium_data_feeder
//
// Upstream stage of the Trivium cipher core. Host plaintext words are buffered
// in a FIFO and sent out MSB-first, one bit for each cipher request. The FIFO
// fill level is exported as a 2-bit buffer-condition code for the cipher's
// control FSM.
//
// Ports:
//   clk         system clock, all state on rising edge
//   rst         asynchronous active-low reset
//   flush       synchronous clear of FIFO, serializer and overflow flag
//   wr_data     host plaintext word
//   wr_en       host write request
//   wr_ready    FIFO can accept a word (not full)
//   bit_req     cipher consumes the presented bit this cycle
//   data        current plaintext bit to cipher
//   strop_data  data is valid
//   last_bit    presented bit is the LSB of its word
//   buff_cond   FIFO status: 00 empty, 01 below AF_LEVEL, 10 almost full, 11 full
//   overflow    sticky: a host write was dropped
// -----------------------------------------------------------------------------
module trivium_data_feeder #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    output logic              wr_ready,
    input  logic              bit_req,
    output logic              data,
    output logic              strop_data,
    output logic              last_bit,
    output logic [1:0]        buff_cond,
    output logic              overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BIT_W = $clog2(DATA_W);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    state_e              state_q,   state_d;
    logic [DATA_W-1:0]   shreg_q,   shreg_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [PTR_W-1:0]    wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q,  rd_ptr_d;
    logic [CNT_W-1:0]    count_q,   count_d;
    logic                overflow_q, overflow_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        push       = 1'b0;
        pop        = 1'b0;

        if (flush) begin
            // Flush outranks every other input: host write and bit request
            // in this cycle are discarded.
            state_d    = IDLE;
            shreg_d    = '0;
            bit_cnt_d  = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            // Fullness is judged on the registered count, so a write into a
            // full FIFO is dropped even if the serializer pops this cycle.
            if (wr_en) begin
                if (full) overflow_d = 1'b1;
                else      push       = 1'b1;
            end

            unique case (state_q)
                IDLE: begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_req) begin
                        if (bit_cnt_q != '0) begin
                            shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
                            bit_cnt_d = bit_cnt_q - BIT_W'(1);
                        end else if (!empty) begin
                            pop = 1'b1;  // back-to-back word, no bubble
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            if (pop) begin
                shreg_d   = mem_q[rd_ptr_q];
                bit_cnt_d = BIT_W'(DATA_W - 1);
                rd_ptr_d  = rd_ptr_q + PTR_W'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: the storage array has no reset; count and pointers define which
    // entries are live, so stale contents are never read.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    always_comb begin
        buff_cond = 2'b01;
        if (empty)                            buff_cond = 2'b00;
        else if (full)                        buff_cond = 2'b11;
        else if (count_q >= CNT_W'(AF_LEVEL)) buff_cond = 2'b10;
    end

    assign wr_ready   = !full;
    assign strop_data = (state_q == SHIFT);
    assign data       = strop_data & shreg_q[DATA_W-1];
    assign last_bit   = strop_data & (bit_cnt_q == '0);
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_trivium_data_feeder.sv
// -----------------------------------------------------------------------------
// tb_trivium_data_feeder
//
// Scoreboard bench for trivium_data_feeder. The stimulus thread drives one
// cycle at a time and advances a word-level reference model (a queue of
// buffered words plus the number of bits left in the word being presented).
// Each accepted word's bits are pushed MSB-first into an expected-bit queue;
// a separate monitor pops and compares whenever the cipher handshake
// (strop_data & bit_req) occurs.
// -----------------------------------------------------------------------------
module tb_trivium_data_feeder;

    localparam int DATA_W   = 8;
    localparam int DEPTH    = 16;
    localparam int AF_LEVEL = 12;

    logic              clk;
    logic              rst;
    logic              flush;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic              wr_ready;
    logic              bit_req;
    logic              data;
    logic              strop_data;
    logic              last_bit;
    logic [1:0]        buff_cond;
    logic              overflow;

    trivium_data_feeder #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .AF_LEVEL(AF_LEVEL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .wr_ready  (wr_ready),
        .bit_req   (bit_req),
        .data      (data),
        .strop_data(strop_data),
        .last_bit  (last_bit),
        .buff_cond (buff_cond),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DATA_W-1:0] m_fifo [$];
    int                m_rem = 0;     // bits left in the presented word
    logic              m_ovf = 1'b0;
    logic [1:0]        exp_bits [$];  // {data, last_bit} in emission order

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_cond(input int n);
        if (n == 0)             return 2'b00;
        else if (n == DEPTH)    return 2'b11;
        else if (n >= AF_LEVEL) return 2'b10;
        else                    return 2'b01;
    endfunction

    task automatic model_clear();
        m_fifo.delete();
        exp_bits.delete();
        m_rem = 0;
        m_ovf = 1'b0;
    endtask

    task automatic check_status(input string tag);
        check({tag, ".strop"},  32'(strop_data), 32'(m_rem > 0));
        check({tag, ".last"},   32'(last_bit),   32'(m_rem == 1));
        check({tag, ".ready"},  32'(wr_ready),   32'(m_fifo.size() != DEPTH));
        check({tag, ".cond"},   32'(buff_cond),  32'(exp_cond(m_fifo.size())));
        check({tag, ".ovf"},    32'(overflow),   32'(m_ovf));
    endtask

    // One clock cycle of stimulus plus model update and status check.
    task automatic cycle(input logic we, input logic [DATA_W-1:0] wd,
                         input logic br, input logic fl);
        bit full;
        wr_en   = we;
        wr_data = wd;
        bit_req = br;
        flush   = fl;
        @(posedge clk);
        if (fl) begin
            model_clear();
        end else begin
            full = (m_fifo.size() == DEPTH);
            if (we && full) m_ovf = 1'b1;
            if (m_rem == 0) begin
                if (m_fifo.size() > 0) begin
                    void'(m_fifo.pop_front());
                    m_rem = DATA_W;
                end
            end else if (br) begin
                m_rem--;
                if (m_rem == 0 && m_fifo.size() > 0) begin
                    void'(m_fifo.pop_front());
                    m_rem = DATA_W;
                end
            end
            if (we && !full) begin
                m_fifo.push_back(wd);
                for (int i = DATA_W - 1; i >= 0; i--)
                    exp_bits.push_back({wd[i], i == 0});
            end
        end
        #1;
        check_status("cyc");
    endtask

    task automatic drain();
        int guard = 0;
        while ((m_fifo.size() > 0 || m_rem > 0) && guard < 1000) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            guard++;
        end
        check("drain.done", 32'(m_fifo.size() + m_rem), 32'd0);
    endtask

    // Monitor: compares every consumed bit against the scoreboard.
    always @(negedge clk) begin
        if (rst && !flush && strop_data && bit_req) begin
            if (exp_bits.size() == 0) begin
                check("sb.unexpected_bit", 32'(strop_data), 32'd0);
            end else begin
                logic [1:0] e;
                e = exp_bits.pop_front();
                check("sb.data", 32'(data),     32'(e[1]));
                check("sb.last", 32'(last_bit), 32'(e[0]));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, ".data"},  32'(data),       32'd0);
        check({tag, ".strop"}, 32'(strop_data), 32'd0);
        check({tag, ".last"},  32'(last_bit),   32'd0);
        check({tag, ".ovf"},   32'(overflow),   32'd0);
        check({tag, ".ready"}, 32'(wr_ready),   32'd1);
        check({tag, ".cond"},  32'(buff_cond),  32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; flush = 1'b0; wr_en = 1'b0; wr_data = '0; bit_req = 1'b0;
        #2;
        check_reset_outputs("reset");
        #10 rst = 1'b1;

        // Single word A5, bit_req held high: strobe two edges after the write.
        cycle(1'b1, 8'hA5, 1'b1, 1'b0);
        check("a5.no_strobe_yet", 32'(strop_data), 32'd0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("a5.strobe", 32'(strop_data), 32'd1);
        check("a5.msb",    32'(data),       32'd1);
        for (int i = 0; i < 9; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        check("a5.idle_cond", 32'(buff_cond), 32'd0);

        // Back-to-back words, no bubble between them.
        cycle(1'b1, 8'hF0, 1'b1, 1'b0);
        cycle(1'b1, 8'h0F, 1'b1, 1'b0);
        for (int i = 0; i < 17; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        drain();

        // Fill to full with the serializer stalled, then overflow.
        for (int i = 0; i < 17; i++) cycle(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
        check("fill.cond_full", 32'(buff_cond), 32'd3);
        check("fill.not_ready", 32'(wr_ready),  32'd0);
        cycle(1'b1, 8'hEE, 1'b0, 1'b0);
        check("fill.overflow", 32'(overflow), 32'd1);

        // Word completes while full and a write arrives: write still dropped.
        for (int i = 0; i < 7; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b1, 8'h5A, 1'b1, 1'b0);
        check("pop_full.cond15", 32'(buff_cond), 32'd2);
        cycle(1'b1, 8'h3C, 1'b0, 1'b0);
        check("pop_full.refill", 32'(buff_cond), 32'd3);
        drain();

        // Flush mid-word with words queued and overflow set.
        cycle(1'b1, 8'hC3, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b1, 8'h77, 1'b1, 1'b1);
        check_reset_outputs("flush");
        cycle(1'b1, 8'h81, 1'b1, 1'b0);
        drain();

        // Randomised traffic with occasional flushes.
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 1)), DATA_W'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 63) == 0));
        drain();

        // Asynchronous reset between clock edges, mid-word.
        cycle(1'b1, 8'h96, 1'b0, 1'b0);
        cycle(1'b1, 8'h69, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_clear();
        @(posedge clk); #1;
        check("async_rst.hold", 32'(strop_data), 32'd0);
        @(negedge clk) rst = 1'b1;
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b1, 8'hB4, 1'b1, 1'b0);
        drain();
        for (int i = 0; i < 2; i++) cycle(1'b0, '0, 1'b1, 1'b0);

        check("sb.empty_at_end", 32'(exp_bits.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
